// File: rtl/jpeg_enc_pkg.sv
// Shared constants, FSM state type and coefficient extraction for the zigzag RLE encoder.
// The optional DPCM path is selected by ZIGZAG_RLE_DC_DPCM_EN in the top-level encoder.
package jpeg_enc_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned DEPTH      = 64;
    localparam int unsigned BLK_W      = DATA_WIDTH * DEPTH;
    localparam int unsigned VAL_W      = DATA_WIDTH + 1;
    localparam int unsigned IDX_W      = 6;
    localparam int unsigned RUN_W      = 6;
    localparam int unsigned ZRL_LEN    = 16;

    localparam logic [3:0] ZRL_RUN  = 4'd15;
    localparam logic [3:0] EOB_SIZE = 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DC   = 2'd1,
        SCAN = 2'd2,
        SEND = 2'd3
    } state_t;

    // Coefficient k sits at the MSB end for k=0, descending toward the LSBs.
    function automatic logic [DATA_WIDTH-1:0] get_coeff(input logic [BLK_W-1:0] blk,
                                                        input logic [IDX_W-1:0] idx);
        logic [BLK_W-1:0] shifted;
        shifted = blk >> (DATA_WIDTH * (DEPTH - 1 - 32'(idx)));
        return shifted[DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/rle_size_category.sv
// JPEG magnitude category and amplitude bits for a signed value one bit wider than a coefficient.
module rle_size_category #(
    parameter int unsigned DATA_WIDTH = jpeg_enc_pkg::DATA_WIDTH
) (
    input  logic [DATA_WIDTH:0] i_value,
    output logic [3:0]          o_size,
    output logic [DATA_WIDTH:0] o_amp
);

    localparam int unsigned VW = DATA_WIDTH + 1;

    logic [VW-1:0] w_mag;
    logic [VW-1:0] w_minus_one;
    logic [VW-1:0] w_mask;

    // Unsigned view of the negation keeps the most negative value exact.
    assign w_mag       = i_value[VW-1] ? VW'(-i_value) : i_value;
    assign w_minus_one = i_value - VW'(1);

    always_comb begin
        o_size = '0;
        for (int i = 0; i < VW; i++) begin
            if (w_mag[i]) o_size = 4'(i + 1);
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < VW; i++) begin
            w_mask[i] = (i < int'(o_size));
        end
    end

    assign o_amp = i_value[VW-1] ? (w_minus_one & w_mask) : i_value;

endmodule

// File: rtl/zigzag_rle_encoder.sv
// Serialises one zigzag 64-coefficient block into DC / AC(run,size,amp) / ZRL / EOB symbols.
// Define ZIGZAG_RLE_DC_DPCM_EN to code DC as a difference against the previous block's DC.
module zigzag_rle_encoder
    import jpeg_enc_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] blk_data,
    input  logic             dc_pred_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_is_dc,
    output logic             out_is_eob,
    output logic             out_is_zrl,
    output logic [3:0]       out_run,
    output logic [3:0]       out_size,
    output logic [VAL_W-1:0] out_amp,
    output logic             out_last
);

    state_t           r_state;
    logic [BLK_W-1:0] r_blk;
    logic [IDX_W-1:0] r_idx;
    logic [RUN_W-1:0] r_run;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_is_dc;
    logic             r_is_eob;
    logic             r_is_zrl;
    logic [3:0]       r_out_run;
    logic [3:0]       r_size;
    logic [VAL_W-1:0] r_amp;
    logic             r_last;

    logic [DATA_WIDTH-1:0] w_coeff;
    logic [DATA_WIDTH-1:0] w_coeff0;
    logic [VAL_W-1:0]      w_dc_val;
    logic [VAL_W-1:0]      w_cat_in;
    logic [VAL_W-1:0]      w_cat_amp;
    logic [3:0]            w_cat_size;
    logic                  w_at_end;
    logic                  w_is_zero;
    logic                  w_xfer;
    logic                  w_do_scan;

    logic                  w_sym_valid;
    logic                  w_sym_eob;
    logic                  w_sym_zrl;
    logic                  w_sym_last;
    logic [3:0]            w_sym_run;
    logic [3:0]            w_sym_size;
    logic [VAL_W-1:0]      w_sym_amp;
    logic [RUN_W-1:0]      w_run_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;

    assign w_coeff   = get_coeff(r_blk, r_idx);
    assign w_coeff0  = get_coeff(r_blk, IDX_W'(0));
    assign w_at_end  = (r_idx == IDX_W'(DEPTH - 1));
    assign w_is_zero = (w_coeff == '0);
    assign w_xfer    = r_out_valid && out_ready;
    // A completed transfer immediately evaluates the next index so back-to-back symbols have no gap.
    assign w_do_scan = (r_state == SCAN) || ((r_state == SEND) && w_xfer && !r_last);
    assign w_cat_in  = (r_state == DC) ? w_dc_val : {w_coeff[DATA_WIDTH-1], w_coeff};

`ifdef ZIGZAG_RLE_DC_DPCM_EN
    logic [DATA_WIDTH-1:0] r_pred;

    assign w_dc_val = {w_coeff0[DATA_WIDTH-1], w_coeff0} - {r_pred[DATA_WIDTH-1], r_pred};

    // Clear wins over a same-cycle load because the DC difference is formed one cycle later.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pred <= '0;
        end else if ((r_state == IDLE) && dc_pred_clr) begin
            r_pred <= '0;
        end else if (w_xfer && r_is_dc) begin
            r_pred <= w_coeff0;
        end
    end
`else
    logic w_unused_pred_clr;

    assign w_unused_pred_clr = dc_pred_clr;
    assign w_dc_val          = {w_coeff0[DATA_WIDTH-1], w_coeff0};
`endif

    rle_size_category #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_size_cat (
        .i_value(w_cat_in),
        .o_size (w_cat_size),
        .o_amp  (w_cat_amp)
    );

    // Outcome of evaluating coeff[r_idx] with the current zero run.
    always_comb begin
        w_sym_valid = 1'b0;
        w_sym_eob   = 1'b0;
        w_sym_zrl   = 1'b0;
        w_sym_last  = 1'b0;
        w_sym_run   = '0;
        w_sym_size  = '0;
        w_sym_amp   = '0;
        w_run_nxt   = r_run;
        w_idx_nxt   = r_idx;
        if (w_is_zero) begin
            w_run_nxt = r_run + RUN_W'(1);
            w_idx_nxt = r_idx + IDX_W'(1);
            if (w_at_end) begin
                w_sym_valid = 1'b1;
                w_sym_eob   = 1'b1;
                w_sym_last  = 1'b1;
                w_sym_size  = EOB_SIZE;
                w_run_nxt   = '0;
            end
        end else if (r_run >= RUN_W'(ZRL_LEN)) begin
            w_sym_valid = 1'b1;
            w_sym_zrl   = 1'b1;
            w_sym_run   = ZRL_RUN;
            w_run_nxt   = r_run - RUN_W'(ZRL_LEN);
        end else begin
            w_sym_valid = 1'b1;
            w_sym_run   = r_run[3:0];
            w_sym_size  = w_cat_size;
            w_sym_amp   = w_cat_amp;
            w_sym_last  = w_at_end;
            w_run_nxt   = '0;
            w_idx_nxt   = r_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_blk       <= '0;
            r_idx       <= '0;
            r_run       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_is_dc     <= 1'b0;
            r_is_eob    <= 1'b0;
            r_is_zrl    <= 1'b0;
            r_out_run   <= '0;
            r_size      <= '0;
            r_amp       <= '0;
            r_last      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_blk      <= blk_data;
                        r_in_ready <= 1'b0;
                        r_state    <= DC;
                    end
                end
                DC: begin
                    r_out_valid <= 1'b1;
                    r_is_dc     <= 1'b1;
                    r_is_eob    <= 1'b0;
                    r_is_zrl    <= 1'b0;
                    r_out_run   <= '0;
                    r_size      <= w_cat_size;
                    r_amp       <= w_cat_amp;
                    r_last      <= 1'b0;
                    r_idx       <= IDX_W'(1);
                    r_run       <= '0;
                    r_state     <= SEND;
                end
                SCAN, SEND: begin
                    if (w_do_scan) begin
                        r_out_valid <= w_sym_valid;
                        r_is_dc     <= 1'b0;
                        r_is_eob    <= w_sym_eob;
                        r_is_zrl    <= w_sym_zrl;
                        r_out_run   <= w_sym_run;
                        r_size      <= w_sym_size;
                        r_amp       <= w_sym_amp;
                        r_last      <= w_sym_last;
                        r_run       <= w_run_nxt;
                        r_idx       <= w_idx_nxt;
                        r_state     <= w_sym_valid ? SEND : SCAN;
                    end else if ((r_state == SEND) && w_xfer) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_is_dc  = r_is_dc;
    assign out_is_eob = r_is_eob;
    assign out_is_zrl = r_is_zrl;
    assign out_run    = r_out_run;
    assign out_size   = r_size;
    assign out_amp    = r_amp;
    assign out_last   = r_last;

endmodule

// File: tb/tb_zigzag_rle_encoder.sv
// Self-checking bench for zigzag_rle_encoder against a symbol-list reference model.
// Honours ZIGZAG_RLE_DC_DPCM_EN the same way as the design.
module tb_zigzag_rle_encoder;
    import jpeg_enc_pkg::*;

    typedef struct packed {
        logic       dc;
        logic       eob;
        logic       zrl;
        logic [3:0] run;
        logic [3:0] size;
        logic [8:0] amp;
        logic       last;
    } sym_t;

    logic             clock;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [BLK_W-1:0] blk_data;
    logic             dc_pred_clr;
    logic             out_valid;
    logic             out_ready;
    logic             out_is_dc;
    logic             out_is_eob;
    logic             out_is_zrl;
    logic [3:0]       out_run;
    logic [3:0]       out_size;
    logic [VAL_W-1:0] out_amp;
    logic             out_last;

    int   checks;
    int   failures;
    int   m_coef [DEPTH];
    int   m_pred;
    sym_t exp_q[$];
    sym_t obs_q[$];
    int   stall_err;
    int   inrdy_err;
    int   lat_err;
    int   timeout_err;

    zigzag_rle_encoder dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .blk_data   (blk_data),
        .dc_pred_clr(dc_pred_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_is_dc  (out_is_dc),
        .out_is_eob (out_is_eob),
        .out_is_zrl (out_is_zrl),
        .out_run    (out_run),
        .out_size   (out_size),
        .out_amp    (out_amp),
        .out_last   (out_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic sym_t mk_sym(input bit dc, input bit eob, input bit zrl,
                                    input int run, input int v, input bit last);
        sym_t s;
        int   mag;
        int   size;
        int   amp;
        mag  = (v < 0) ? -v : v;
        size = 0;
        while (mag > 0) begin
            size++;
            mag = mag / 2;
        end
        amp    = (v >= 0) ? v : v + (1 << size) - 1;
        s.dc   = dc;
        s.eob  = eob;
        s.zrl  = zrl;
        s.run  = 4'(run);
        s.size = 4'(size);
        s.amp  = 9'(amp);
        s.last = last;
        return s;
    endfunction

    function automatic sym_t dut_sym();
        return {out_is_dc, out_is_eob, out_is_zrl, out_run, out_size, out_amp, out_last};
    endfunction

    function automatic logic [BLK_W-1:0] pack_blk();
        logic [BLK_W-1:0] b;
        b = '0;
        for (int k = 0; k < DEPTH; k++) b[BLK_W-1-k*DATA_WIDTH -: DATA_WIDTH] = 8'(m_coef[k]);
        return b;
    endfunction

    task automatic clear_coef();
        for (int k = 0; k < DEPTH; k++) m_coef[k] = 0;
    endtask

    // Expected symbol list straight from the JPEG run-length rules.
    task automatic model_block(input bit clr);
        int dc;
        int run;
        exp_q.delete();
`ifdef ZIGZAG_RLE_DC_DPCM_EN
        if (clr) m_pred = 0;
        dc     = m_coef[0] - m_pred;
        m_pred = m_coef[0];
`else
        dc = m_coef[0];
        if (clr) dc = m_coef[0];
`endif
        exp_q.push_back(mk_sym(1, 0, 0, 0, dc, 0));
        run = 0;
        for (int k = 1; k < DEPTH; k++) begin
            if (m_coef[k] == 0) begin
                run++;
            end else begin
                while (run > 15) begin
                    exp_q.push_back(mk_sym(0, 0, 1, 15, 0, 0));
                    run -= 16;
                end
                exp_q.push_back(mk_sym(0, 0, 0, run, m_coef[k], k == DEPTH - 1));
                run = 0;
            end
        end
        if (m_coef[DEPTH-1] == 0) exp_q.push_back(mk_sym(0, 1, 0, 0, 0, 1));
    endtask

    // Loads m_coef and collects transferred symbols; mode 0 ready, 1 toggling, 2 random.
    task automatic run_block(input int mode, input bit clr);
        sym_t prev;
        sym_t cur;
        bit   stalled;
        bit   done;
        int   cyc;
        obs_q.delete();
        stall_err   = 0;
        inrdy_err   = 0;
        lat_err     = 0;
        timeout_err = 0;
        @(negedge clock);
        in_valid    = 1'b1;
        dc_pred_clr = clr;
        blk_data    = pack_blk();
        out_ready   = 1'b0;
        if (!in_ready) lat_err++;
        @(negedge clock);
        in_valid    = 1'b0;
        dc_pred_clr = 1'b0;
        if (out_valid) lat_err++;
        cyc     = 0;
        done    = 0;
        stalled = 0;
        prev    = '0;
        while (!done && cyc < 2000) begin
            @(negedge clock);
            cyc++;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = cyc[0];
                default: out_ready = 1'($urandom);
            endcase
            cur = dut_sym();
            if (cyc == 1 && !out_valid) lat_err++;
            if (stalled && (!out_valid || cur != prev)) stall_err++;
            if (in_ready) inrdy_err++;
            stalled = out_valid && !out_ready;
            prev    = cur;
            if (out_valid && out_ready) begin
                obs_q.push_back(cur);
                if (out_last) done = 1;
            end
        end
        if (!done) timeout_err = 1;
        @(negedge clock);
        out_ready = 1'b0;
        if (!in_ready || out_valid) inrdy_err++;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        dc_pred_clr = 1'b0;
        blk_data    = '0;
        m_pred      = 0;
        repeat (3) @(negedge clock);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (dut_sym() !== sym_t'(0)) begin
            failures++;
            $display("FAIL reset_fields got=%h exp=0", dut_sym());
        end
    endtask

    task automatic test_dc_only();
        clear_coef();
        m_coef[0] = 5;
        model_block(0);
        run_block(0, 0);
        checks++;
        if (obs_q.size() !== 2) begin
            failures++;
            $display("FAIL t1_count got=%0d exp=2", obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL t1_sym%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (obs_q.size() > 1 && (obs_q[1].eob !== 1'b1 || obs_q[1].last !== 1'b1)) begin
            failures++;
            $display("FAIL t1_eob got eob=%b last=%b exp 1/1", obs_q[1].eob, obs_q[1].last);
        end
        checks++;
        if (stall_err + inrdy_err + lat_err + timeout_err !== 0) begin
            failures++;
            $display("FAIL t1_proto got stall=%0d inrdy=%0d lat=%0d to=%0d exp 0", stall_err, inrdy_err, lat_err, timeout_err);
        end
    endtask

    task automatic test_single_ac();
        clear_coef();
        m_coef[1] = -3;
        model_block(0);
        run_block(0, 0);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL t2_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL t2_sym%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (obs_q.size() > 1 && (obs_q[1].run !== 4'd0 || obs_q[1].size !== 4'd2 || obs_q[1].amp !== 9'd0)) begin
            failures++;
            $display("FAIL t2_ac got run=%0d size=%0d amp=%0d exp 0/2/0", obs_q[1].run, obs_q[1].size, obs_q[1].amp);
        end
    endtask

    task automatic test_zrl(input int mode, input string tag);
        int nzrl;
        clear_coef();
        m_coef[20] = 1;
        model_block(0);
        run_block(mode, 0);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL %s_count got=%0d exp=%0d", tag, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s_sym%0d got=%h exp=%h", tag, i, obs_q[i], exp_q[i]);
            end
        end
        nzrl = 0;
        foreach (obs_q[i]) if (obs_q[i].zrl) nzrl++;
        checks++;
        if (nzrl !== 1) begin
            failures++;
            $display("FAIL %s_nzrl got=%0d exp=1", tag, nzrl);
        end
        checks++;
        if (stall_err + inrdy_err + lat_err + timeout_err !== 0) begin
            failures++;
            $display("FAIL %s_proto got stall=%0d inrdy=%0d lat=%0d to=%0d exp 0", tag, stall_err, inrdy_err, lat_err, timeout_err);
        end
    endtask

    task automatic test_last_coeff();
        clear_coef();
        m_coef[63] = -1;
        model_block(0);
        run_block(2, 0);
        checks++;
        if (obs_q.size() !== 5) begin
            failures++;
            $display("FAIL t4_count got=%0d exp=5", obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL t4_sym%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (obs_q.size() > 0 && (obs_q[obs_q.size()-1].eob !== 1'b0 || obs_q[obs_q.size()-1].run !== 4'd14)) begin
            failures++;
            $display("FAIL t4_tail got eob=%b run=%0d exp 0/14", obs_q[obs_q.size()-1].eob, obs_q[obs_q.size()-1].run);
        end
    endtask

`ifdef ZIGZAG_RLE_DC_DPCM_EN
    task automatic test_dpcm();
        int dc_vals [3];
        bit clr_vals [3];
        int exp_size [3];
        int exp_amp [3];
        dc_vals  = '{10, 7, 7};
        clr_vals = '{0, 0, 1};
        exp_size = '{4, 2, 3};
        exp_amp  = '{10, 0, 7};
        reset_n = 1'b0;
        m_pred  = 0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int b = 0; b < 3; b++) begin
            clear_coef();
            m_coef[0] = dc_vals[b];
            model_block(clr_vals[b]);
            run_block(2, clr_vals[b]);
            checks++;
            if (obs_q.size() < 1 || obs_q[0].size !== 4'(exp_size[b]) || obs_q[0].amp !== 9'(exp_amp[b])) begin
                failures++;
                $display("FAIL dpcm_blk%0d got=%h exp size=%0d amp=%0d", b, (obs_q.size() > 0) ? obs_q[0] : sym_t'(0), exp_size[b], exp_amp[b]);
            end
        end
    endtask
`endif

    task automatic test_random();
        int dens;
        int v;
        bit clr;
        for (int b = 0; b < 20; b++) begin
            dens = int'($urandom_range(3, 40));
            for (int k = 0; k < DEPTH; k++) begin
                v = $signed(8'($urandom));
                if (v == 0) v = 1;
                m_coef[k] = (int'($urandom_range(0, 99)) < dens || k == 0) ? v : 0;
            end
            if (b == 3) m_coef[0] = -128;
            if (b == 4) m_coef[10] = -128;
            if (b == 5) m_coef[63] = 127;
            if (b == 6) m_coef[0] = 0;
            clr = 1'($urandom);
            model_block(clr);
            run_block(int'($urandom_range(0, 2)), clr);
            checks++;
            if (obs_q.size() !== exp_q.size()) begin
                failures++;
                $display("FAIL rnd%0d_count got=%0d exp=%0d", b, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL rnd%0d_sym%0d got=%h exp=%h", b, i, obs_q[i], exp_q[i]);
                end
            end
            checks++;
            if (stall_err + inrdy_err + lat_err + timeout_err !== 0) begin
                failures++;
                $display("FAIL rnd%0d_proto got stall=%0d inrdy=%0d lat=%0d to=%0d exp 0", b, stall_err, inrdy_err, lat_err, timeout_err);
            end
        end
    endtask

    task automatic test_reset_mid_block();
        clear_coef();
        m_coef[0] = 3;
        m_coef[5] = 9;
        @(negedge clock);
        in_valid  = 1'b1;
        blk_data  = pack_blk();
        out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        out_ready = 1'b0;
        repeat (10) @(negedge clock);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pending got out_valid=%b exp 1", out_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_async got out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
        end
        m_pred = 0;
        @(negedge clock);
        reset_n = 1'b1;
        clear_coef();
        m_coef[0]  = -20;
        m_coef[33] = 64;
        m_coef[34] = -2;
        model_block(0);
        run_block(2, 0);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL midrst_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL midrst_sym%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_dc_only();
        test_single_ac();
        test_zrl(0, "t3");
        test_last_coeff();
        test_zrl(1, "t5_bp");
`ifdef ZIGZAG_RLE_DC_DPCM_EN
        test_dpcm();
`endif
        test_random();
        test_reset_mid_block();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
